// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C EEPROM controllers: engine command
// codes, EEPROM device-type nibble and the read controller's states.
package i2c_pkg;

  localparam logic [3:0] EEPROM_DEV_TYPE = 4'b1010;

  typedef enum logic [2:0] {
    CMD_NONE      = 3'd0,
    CMD_START     = 3'd1,
    CMD_RSTART    = 3'd2,
    CMD_WRITE     = 3'd3,
    CMD_READ_ACK  = 3'd4,
    CMD_READ_NACK = 3'd5,
    CMD_STOP      = 3'd6
  } i2c_cmd_e;

  typedef enum logic [3:0] {
    S_IDLE,
    S_START,
    S_DEV_W,
    S_ADDR_H,
    S_ADDR_L,
    S_RSTART,
    S_DEV_R,
    S_RD_WAIT,
    S_RD,
    S_PUSH,
    S_STOP,
    S_RETRY_STOP,
    S_ERR_STOP
  } rd_state_e;

endpackage

// File: rtl/i2c_read_from_memory.sv
// Reads N bytes from a serial EEPROM through the I2C byte engine
// and pushes every received byte into the downstream FIFO.
module i2c_read_from_memory
  import i2c_pkg::*;
#(
  parameter int         ADDR_W    = 15,
  parameter int         COUNT_W   = 12,
  parameter logic [3:0] DEV_TYPE  = EEPROM_DEV_TYPE,
  parameter int         MAX_RETRY = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               run,
  input  logic [COUNT_W-1:0] number_of_bytes,
  input  logic [ADDR_W-1:0]  memory_address,
  input  logic [2:0]         memory_number,
  input  logic               i2c_busy,
  input  logic               i2c_done,
  input  logic               i2c_ack_n,
  input  logic [7:0]         i2c_rx_byte,
  output logic               i2c_cmd_valid,
  output logic [2:0]         i2c_cmd,
  output logic [7:0]         i2c_tx_byte,
  input  logic               fifo_full,
  output logic               fifo_write,
  output logic [7:0]         fifo_data,
  output logic               busy,
  output logic               done,
  output logic               error
);

  localparam int RW = $clog2(MAX_RETRY + 1);

  rd_state_e          state_q, state_d;
  logic               issued_q, issued_d;
  logic [COUNT_W-1:0] rem_q, rem_d;
  logic [RW-1:0]      retry_q, retry_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [2:0]         mem_q, mem_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               error_q, error_d;

  i2c_cmd_e   sel_cmd;
  logic [7:0] sel_byte;
  logic       strobe;
  logic       fin;
  logic [15:0] addr16;

  // Bit 15 of the on-wire address is always 0.
  assign addr16 = {1'b0, 15'(addr_q)};

  always_comb begin
    state_d       = state_q;
    issued_d      = issued_q;
    rem_d         = rem_q;
    retry_d       = retry_q;
    addr_d        = addr_q;
    mem_d         = mem_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    error_d       = error_q;
    sel_cmd       = CMD_NONE;
    sel_byte      = '0;
    fifo_write    = 1'b0;
    fifo_data     = '0;
    i2c_cmd_valid = 1'b0;
    i2c_cmd       = '0;
    i2c_tx_byte   = '0;
    fin           = issued_q & i2c_done;

    unique case (state_q)
      S_IDLE: begin
        if (run) begin
          addr_d  = memory_address;
          mem_d   = memory_number;
          rem_d   = number_of_bytes;
          retry_d = '0;
          error_d = 1'b0;
          if (number_of_bytes == '0) begin
            done_d = 1'b1;
          end else begin
            busy_d  = 1'b1;
            state_d = S_START;
          end
        end
      end
      S_START: begin
        sel_cmd = CMD_START;
        if (fin) state_d = S_DEV_W;
      end
      S_DEV_W: begin
        sel_cmd  = CMD_WRITE;
        sel_byte = {DEV_TYPE, mem_q, 1'b0};
        if (fin) begin
          if (!i2c_ack_n) begin
            state_d = S_ADDR_H;
          end else if (retry_q == RW'(MAX_RETRY)) begin
            state_d = S_ERR_STOP;
          end else begin
            retry_d = retry_q + RW'(1);
            state_d = S_RETRY_STOP;
          end
        end
      end
      S_ADDR_H: begin
        sel_cmd  = CMD_WRITE;
        sel_byte = addr16[15:8];
        if (fin) state_d = i2c_ack_n ? S_ERR_STOP : S_ADDR_L;
      end
      S_ADDR_L: begin
        sel_cmd  = CMD_WRITE;
        sel_byte = addr16[7:0];
        if (fin) state_d = i2c_ack_n ? S_ERR_STOP : S_RSTART;
      end
      S_RSTART: begin
        sel_cmd = CMD_RSTART;
        if (fin) state_d = S_DEV_R;
      end
      S_DEV_R: begin
        sel_cmd  = CMD_WRITE;
        sel_byte = {DEV_TYPE, mem_q, 1'b1};
        if (fin) state_d = i2c_ack_n ? S_ERR_STOP : S_RD_WAIT;
      end
      S_RD_WAIT: begin
        if (!fifo_full) state_d = S_RD;
      end
      S_RD: begin
        sel_cmd = (rem_q == COUNT_W'(1)) ? CMD_READ_NACK : CMD_READ_ACK;
        if (!i2c_busy) state_d = S_PUSH;
      end
      S_PUSH: begin
        if (fin) begin
          fifo_write = 1'b1;
          fifo_data  = i2c_rx_byte;
          rem_d      = rem_q - COUNT_W'(1);
          state_d    = (rem_q == COUNT_W'(1)) ? S_STOP : S_RD_WAIT;
        end
      end
      S_STOP: begin
        sel_cmd = CMD_STOP;
        if (fin) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      S_RETRY_STOP: begin
        sel_cmd = CMD_STOP;
        if (fin) state_d = S_START;
      end
      S_ERR_STOP: begin
        sel_cmd = CMD_STOP;
        if (fin) begin
          error_d = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    strobe = (sel_cmd != CMD_NONE) && !issued_q && !i2c_busy;
    if (strobe) begin
      issued_d      = 1'b1;
      i2c_cmd_valid = 1'b1;
      i2c_cmd       = sel_cmd;
      if (sel_cmd == CMD_WRITE) i2c_tx_byte = sel_byte;
    end
    if (fin) issued_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      issued_q <= 1'b0;
      rem_q    <= '0;
      retry_q  <= '0;
      addr_q   <= '0;
      mem_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      issued_q <= issued_d;
      rem_q    <= rem_d;
      retry_q  <= retry_d;
      addr_q   <= addr_d;
      mem_q    <= mem_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      error_q  <= error_d;
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign error = error_q;

endmodule

// File: tb/tb_i2c_read_from_memory.sv
// Bench for i2c_read_from_memory: EEPROM responder on the engine port,
// a four-deep FIFO model, and per-scenario self-checking tasks.
module tb_i2c_read_from_memory;
  import i2c_pkg::*;

  localparam int NRETRY = 8;
  localparam logic [3:0] DEVN = 4'b1010;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        run = 1'b0;
  logic [11:0] nb = '0;
  logic [14:0] ma = '0;
  logic [2:0]  mn = '0;
  logic        i2c_busy = 1'b0;
  logic        i2c_done = 1'b0;
  logic        i2c_ack_n = 1'b0;
  logic [7:0]  i2c_rx_byte = '0;
  logic        i2c_cmd_valid;
  logic [2:0]  i2c_cmd;
  logic [7:0]  i2c_tx_byte;
  logic        fifo_full = 1'b0;
  logic        fifo_write;
  logic [7:0]  fifo_data;
  logic        busy, done, error;

  i2c_read_from_memory dut (
    .clk(clk), .reset(reset), .run(run),
    .number_of_bytes(nb), .memory_address(ma), .memory_number(mn),
    .i2c_busy(i2c_busy), .i2c_done(i2c_done), .i2c_ack_n(i2c_ack_n),
    .i2c_rx_byte(i2c_rx_byte), .i2c_cmd_valid(i2c_cmd_valid),
    .i2c_cmd(i2c_cmd), .i2c_tx_byte(i2c_tx_byte),
    .fifo_full(fifo_full), .fifo_write(fifo_write), .fifo_data(fifo_data),
    .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  // EEPROM responder
  logic [7:0]  mem [0:32767];
  logic [14:0] ptr = '0;
  int          byte_idx = 0;
  int          rsp_cnt = 0;
  int          devw_seen = 0;
  int          devw_base = 0;
  int          nack_n = 0;
  bit          always_nack = 0;
  int          viol = 0;
  logic        pend_ack = 1'b0;
  logic [7:0]  pend_rx = '0;
  logic [2:0]  cmd_log [$];
  logic [7:0]  tx_log [$];

  always @(posedge clk) begin
    i2c_done <= 1'b0;
    if (reset) begin
      i2c_busy <= 1'b0;
      rsp_cnt  <= 0;
    end else begin
      if (i2c_cmd_valid && i2c_busy) viol <= viol + 1;
      if (i2c_busy) begin
        if (rsp_cnt == 0) begin
          i2c_busy    <= 1'b0;
          i2c_done    <= 1'b1;
          i2c_ack_n   <= pend_ack;
          i2c_rx_byte <= pend_rx;
        end else begin
          rsp_cnt <= rsp_cnt - 1;
        end
      end else if (i2c_cmd_valid) begin
        i2c_busy <= 1'b1;
        rsp_cnt  <= $urandom_range(0, 2);
        cmd_log.push_back(i2c_cmd);
        pend_ack <= 1'b0;
        pend_rx  <= 8'h00;
        case (i2c_cmd_e'(i2c_cmd))
          CMD_START, CMD_RSTART: byte_idx <= 0;
          CMD_WRITE: begin
            tx_log.push_back(i2c_tx_byte);
            byte_idx <= byte_idx + 1;
            if (byte_idx == 0 && !i2c_tx_byte[0]) begin
              devw_seen <= devw_seen + 1;
              if (always_nack || (devw_seen - devw_base) < nack_n)
                pend_ack <= 1'b1;
            end
            if (byte_idx == 1) ptr[14:8] <= i2c_tx_byte[6:0];
            if (byte_idx == 2) ptr[7:0] <= i2c_tx_byte;
          end
          CMD_READ_ACK, CMD_READ_NACK: begin
            pend_rx <= mem[ptr];
            ptr     <= ptr + 15'd1;
          end
          default: ;
        endcase
      end
    end
  end

  // four-entry FIFO model
  logic [7:0] fifo_q [$];
  logic [7:0] out_log [$];
  bit         auto_pop = 0;
  bit         pop_one = 0;
  bit         tb_push = 0;
  logic [7:0] tb_data = '0;
  int         ovf = 0;

  always @(posedge clk) begin
    if (fifo_write) begin
      if (fifo_q.size() >= 4) ovf <= ovf + 1;
      else fifo_q.push_back(fifo_data);
    end
    if (tb_push && fifo_q.size() < 4) fifo_q.push_back(tb_data);
    if ((pop_one || (auto_pop && $urandom_range(0, 2) == 0))
        && fifo_q.size() > 0)
      out_log.push_back(fifo_q.pop_front());
    fifo_full <= (fifo_q.size() >= 4);
  end

  int cbase, tbase, obase;
  logic [2:0] exp_cmd [$];
  logic [7:0] exp_tx [$];

  function automatic void build_exp(logic [2:0] m, logic [14:0] a,
                                    int n, int r, bit fail);
    logic [7:0] dw;
    dw = {DEVN, m, 1'b0};
    exp_cmd.delete();
    exp_tx.delete();
    for (int i = 0; i < r; i++) begin
      exp_cmd.push_back(CMD_START);
      exp_cmd.push_back(CMD_WRITE);
      exp_tx.push_back(dw);
      exp_cmd.push_back(CMD_STOP);
    end
    if (!fail) begin
      exp_cmd.push_back(CMD_START);
      for (int i = 0; i < 3; i++) exp_cmd.push_back(CMD_WRITE);
      exp_cmd.push_back(CMD_RSTART);
      exp_cmd.push_back(CMD_WRITE);
      for (int i = 0; i < n; i++)
        exp_cmd.push_back(i == n - 1 ? CMD_READ_NACK : CMD_READ_ACK);
      exp_cmd.push_back(CMD_STOP);
      exp_tx.push_back(dw);
      exp_tx.push_back({1'b0, a[14:8]});
      exp_tx.push_back(a[7:0]);
      exp_tx.push_back({DEVN, m, 1'b1});
    end
  endfunction

  function automatic int diff_all(logic [14:0] a, int n, int skip);
    int bad;
    bad = 0;
    if (cmd_log.size() - cbase != exp_cmd.size()) bad++;
    else foreach (exp_cmd[i])
      if (cmd_log[cbase + i] !== exp_cmd[i]) bad++;
    if (tx_log.size() - tbase != exp_tx.size()) bad++;
    else foreach (exp_tx[i])
      if (tx_log[tbase + i] !== exp_tx[i]) bad++;
    if (out_log.size() - obase - skip != n) bad++;
    else for (int i = 0; i < n; i++)
      if (out_log[obase + skip + i] !== mem[15'(int'(a) + i)]) bad++;
    return bad;
  endfunction

  function automatic int count_reads();
    int c;
    c = 0;
    for (int i = cbase; i < cmd_log.size(); i++)
      if (cmd_log[i] == CMD_READ_ACK || cmd_log[i] == CMD_READ_NACK) c++;
    return c;
  endfunction

  task automatic start_run(logic [2:0] m, logic [14:0] a, int n, int nk);
    @(negedge clk);
    mn = m; ma = a; nb = 12'(n);
    nack_n = nk;
    cbase = cmd_log.size();
    tbase = tx_log.size();
    obase = out_log.size();
    devw_base = devw_seen;
    run = 1'b1;
    @(negedge clk);
    run = 1'b0;
  endtask

  task automatic wait_finish(input bit poke, output bit to,
                             output int dcnt, output int gap);
    int last_id;
    last_id = -100;
    to = 1; dcnt = 0; gap = -1;
    for (int c = 0; c < 8000; c++) begin
      @(negedge clk);
      run = poke && (c == 4) && busy;
      if (i2c_done) last_id = c;
      if (done) begin dcnt++; gap = c - last_id; end
      if (!busy) begin to = 0; break; end
    end
    run = 1'b0;
  endtask

  task automatic drain();
    for (int c = 0; c < 400 && fifo_q.size() != 0; c++) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({i2c_cmd_valid, i2c_cmd, i2c_tx_byte} !== 12'h0) begin
      n_fail++; $display("FAIL reset_cmd: got %0h, expected 0",
                         {i2c_cmd_valid, i2c_cmd, i2c_tx_byte});
    end
    n_checks++;
    if ({fifo_write, fifo_data, busy, done, error} !== 12'h0) begin
      n_fail++; $display("FAIL reset_out: got %0h, expected 0",
                         {fifo_write, fifo_data, busy, done, error});
    end
    reset = 1'b0;
  endtask

  task automatic test_basic();
    bit to; int dcnt, gap, bad;
    for (int i = 0; i < 5; i++) mem[15'h0123 + i] = 8'(8'hA0 + i);
    auto_pop = 1;
    build_exp(3'd2, 15'h0123, 5, 0, 0);
    start_run(3'd2, 15'h0123, 5, 0);
    wait_finish(0, to, dcnt, gap);
    drain();
    n_checks++;
    if (to) begin n_fail++; $display("FAIL basic_timeout: got busy, expected idle"); end
    bad = diff_all(15'h0123, 5, 0);
    n_checks++;
    if (bad != 0) begin n_fail++; $display("FAIL basic_seq: got %0d diffs, expected 0", bad); end
    n_checks++;
    if (tx_log[tbase] !== 8'hA4 || out_log[obase + 4] !== 8'hA4) begin
      n_fail++; $display("FAIL basic_bytes: got %0h/%0h, expected a4/a4",
                         tx_log[tbase], out_log[obase + 4]);
    end
    n_checks++;
    if (dcnt != 1 || gap != 1) begin
      n_fail++; $display("FAIL basic_done: got cnt %0d gap %0d, expected 1 1", dcnt, gap);
    end
  endtask

  task automatic test_zero();
    int bz;
    start_run(3'd5, 15'h0042, 0, 0);
    n_checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL zero_done: got done %0b busy %0b, expected 1 0", done, busy);
    end
    bz = 0;
    repeat (20) begin @(negedge clk); if (busy || done) bz++; end
    n_checks++;
    if (bz != 0 || cmd_log.size() != cbase) begin
      n_fail++; $display("FAIL zero_quiet: got %0d/%0d, expected 0/0",
                         bz, cmd_log.size() - cbase);
    end
  endtask

  task automatic test_retry();
    bit to; int dcnt, gap, bad;
    auto_pop = 1;
    build_exp(3'd1, 15'h7F00, 3, 3, 0);
    start_run(3'd1, 15'h7F00, 3, 3);
    wait_finish(0, to, dcnt, gap);
    drain();
    bad = diff_all(15'h7F00, 3, 0);
    n_checks++;
    if (to || bad != 0) begin
      n_fail++; $display("FAIL retry_seq: got %0d diffs to %0b, expected 0 0", bad, to);
    end
    n_checks++;
    if (error !== 1'b0 || dcnt != 1) begin
      n_fail++; $display("FAIL retry_end: got err %0b done %0d, expected 0 1", error, dcnt);
    end
  endtask

  task automatic test_retry_exhaust();
    bit to; int dcnt, gap, bad;
    always_nack = 1;
    build_exp(3'd7, 15'h0010, 0, NRETRY + 1, 1);
    start_run(3'd7, 15'h0010, 4, 0);
    wait_finish(0, to, dcnt, gap);
    always_nack = 0;
    bad = diff_all(15'h0010, 0, 0);
    n_checks++;
    if (to || bad != 0) begin
      n_fail++; $display("FAIL exhaust_seq: got %0d diffs to %0b, expected 0 0", bad, to);
    end
    n_checks++;
    if (error !== 1'b1 || dcnt != 0) begin
      n_fail++; $display("FAIL exhaust_end: got err %0b done %0d, expected 1 0", error, dcnt);
    end
  endtask

  task automatic test_fifo_full();
    bit to; int dcnt, gap, bad, r0, r1;
    auto_pop = 0;
    drain();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); tb_push = 1; tb_data = 8'(8'h11 + i);
    end
    @(negedge clk); tb_push = 0;
    build_exp(3'd3, 15'h2345, 2, 0, 0);
    start_run(3'd3, 15'h2345, 2, 0);
    n_checks++;
    if (error !== 1'b0) begin n_fail++; $display("FAIL err_clear: got %0b, expected 0", error); end
    repeat (60) @(negedge clk);
    r0 = count_reads();
    @(negedge clk); pop_one = 1;
    @(negedge clk); pop_one = 0;
    repeat (60) @(negedge clk);
    r1 = count_reads();
    n_checks++;
    if (r0 != 0 || r1 != 1) begin
      n_fail++; $display("FAIL full_hold: got %0d/%0d reads, expected 0/1", r0, r1);
    end
    auto_pop = 1;
    wait_finish(0, to, dcnt, gap);
    drain();
    bad = diff_all(15'h2345, 2, 4);
    for (int i = 0; i < 4; i++)
      if (out_log[obase + i] !== 8'(8'h11 + i)) bad++;
    n_checks++;
    if (to || bad != 0 || dcnt != 1) begin
      n_fail++; $display("FAIL full_data: got %0d diffs done %0d, expected 0 1", bad, dcnt);
    end
  endtask

  task automatic test_reset_mid();
    bit to; int dcnt, gap, bad, ncmd;
    auto_pop = 1;
    start_run(3'd4, 15'h1ABC, 3, 0);
    for (int c = 0; c < 500 && tx_log.size() - tbase < 3; c++) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({i2c_cmd_valid, i2c_cmd, i2c_tx_byte, fifo_write, fifo_data,
         busy, done, error} !== 24'h0) begin
      n_fail++; $display("FAIL midreset_out: got %0h, expected 0",
        {i2c_cmd_valid, i2c_cmd, i2c_tx_byte, fifo_write, fifo_data, busy, done, error});
    end
    reset = 1'b0;
    repeat (10) @(negedge clk);
    ncmd = cmd_log.size() - cbase;
    n_checks++;
    if (ncmd != 4) begin n_fail++; $display("FAIL midreset_nostop: got %0d cmds, expected 4", ncmd); end
    build_exp(3'd6, 15'h0400, 4, 0, 0);
    start_run(3'd6, 15'h0400, 4, 0);
    wait_finish(0, to, dcnt, gap);
    drain();
    bad = diff_all(15'h0400, 4, 0);
    n_checks++;
    if (to || bad != 0 || dcnt != 1) begin
      n_fail++; $display("FAIL midreset_rerun: got %0d diffs done %0d, expected 0 1", bad, dcnt);
    end
  endtask

  task automatic test_random();
    bit to; int dcnt, gap, bad, n, nk, post;
    logic [2:0] m; logic [14:0] a; bit poke;
    auto_pop = 1;
    for (int k = 0; k < 8; k++) begin
      m = 3'($urandom_range(0, 7));
      a = 15'($urandom);
      n = $urandom_range(1, 9);
      nk = $urandom_range(0, 2);
      poke = 1'($urandom_range(0, 1));
      build_exp(m, a, n, nk, 0);
      start_run(m, a, n, nk);
      wait_finish(poke, to, dcnt, gap);
      drain();
      post = 0;
      repeat (4) begin @(negedge clk); if (busy) post++; end
      bad = diff_all(a, n, 0);
      n_checks++;
      if (to || bad != 0 || dcnt != 1 || gap != 1 || post != 0) begin
        n_fail++;
        $display("FAIL random_%0d: got diffs %0d done %0d gap %0d post %0d, expected 0 1 1 0",
                 k, bad, dcnt, gap, post);
      end
    end
  endtask

  task automatic test_protocol();
    n_checks++;
    if (viol != 0 || ovf != 0) begin
      n_fail++; $display("FAIL protocol: got viol %0d ovf %0d, expected 0 0", viol, ovf);
    end
  endtask

  initial begin
    for (int i = 0; i < 32768; i++) mem[i] = 8'($urandom);
    test_reset();
    test_basic();
    test_zero();
    test_retry();
    test_retry_exhaust();
    test_fifo_full();
    test_reset_mid();
    test_random();
    test_protocol();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
